reg_file_sb: RTL
================

REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 The block SHALL have parameter DATA_LENGTH, default 32, meaning register data width in bits.
REQ-002 The block SHALL have parameter REG_ADDR_LENGTH, default 5, meaning register address width.
REQ-003 The block SHALL have parameter MEM_DEPTH, default 32, meaning number of registers; MEM_DEPTH equals 2^REG_ADDR_LENGTH.
REQ-004 The block SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1 and disabled when 0.
REQ-005 The block SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, meaning the reset, synchronous and active-high.
REQ-007 The block SHALL have ports addrA and addrB, input, REG_ADDR_LENGTH, meaning the read addresses.
REQ-008 The block SHALL have ports dataA and dataB, output, DATA_LENGTH, meaning the read data.
REQ-009 The block SHALL have ports busyA and busyB, output, 1, meaning the addressed register awaits a pending writeback.
REQ-010 The block SHALL have ports addrD (REG_ADDR_LENGTH), dataD (DATA_LENGTH) and RegWEn (1), inputs, meaning the writeback port.
REQ-011 The block SHALL have ports issueEn (1) and issueAddr (REG_ADDR_LENGTH), inputs, meaning mark issueAddr as pending.
REQ-012 The block SHALL have port ready, output, 1, meaning initialisation is complete and the file accepts operations.

Function
REQ-013 The block SHALL implement a two-state FSM: CLEAR and RUN.
REQ-014 In CLEAR, a counter cnt SHALL write zero to REG[cnt] each cycle and increment, going to RUN on the edge that clears entry MEM_DEPTH-1.
REQ-015 ready SHALL be 1 exactly when the state is RUN (registered).
REQ-016 While ready is 0, RegWEn and issueEn SHALL be ignored, dataA/dataB SHALL read 0, and busyA/busyB SHALL read 0.
REQ-017 In RUN, a write SHALL occur at the rising edge when RegWEn=1 and addrD!=0: REG[addrD] <= dataD.
REQ-018 Register 0 SHALL always read 0 and SHALL never be written or marked busy.
REQ-019 Reads SHALL be combinational: dataA=REG[addrA], dataB=REG[addrB].
REQ-020 With BYPASS=1, if ready, RegWEn=1, addrD!=0 and addrD==addrA, dataA SHALL equal dataD in the same cycle; the same rule SHALL apply to port B.
REQ-021 With BYPASS=0, a written value SHALL become readable the cycle after the write edge.
REQ-022 A MEM_DEPTH-bit busy vector SHALL be maintained: issueEn=1 with issueAddr!=0 sets busy[issueAddr]; RegWEn=1 with addrD!=0 clears busy[addrD].
REQ-023 When issue and writeback target the same nonzero address in one cycle, the issue SHALL win, leaving busy set and still writing the data.
REQ-024 Issue and writeback to different addresses in one cycle SHALL both take effect.
REQ-025 busyA SHALL equal busy[addrA]; with BYPASS=1, busyA SHALL be 0 when a same-cycle writeback to addrA (addrA!=0) is present. The same rule SHALL apply to busyB.
REQ-026 Issue of an already-busy register SHALL keep it busy; writeback to a non-busy register SHALL write the data and leave busy at 0.

Reset
REQ-027 While rst=1, the state SHALL be CLEAR, cnt SHALL be 0, the busy vector SHALL be 0 and ready SHALL be 0; no register SHALL be written.
REQ-028 After rst falls, ready SHALL rise at the MEM_DEPTH-th rising edge (edge 32 with defaults), with all registers reading 0.
REQ-029 rst asserted during CLEAR or RUN SHALL abort and restart initialisation from cnt=0, discarding all pending busy state.

Verification
REQ-030 Release rst, count edges -> ready=0 for 31 edges, 1 after edge 32; reading every address returns 0x00000000.
REQ-031 In RUN, write 0xDEADBEEF to x5, then read addrA=5 the next cycle -> dataA=0xDEADBEEF; write to x0 -> x0 reads 0.
REQ-032 BYPASS=1: RegWEn=1, addrD=7, dataD=0x12345678, addrB=7 in the same cycle -> dataB=0x12345678; with BYPASS=0 -> old value until next cycle.
REQ-033 Issue x9, then addrA=9 -> busyA=1; writeback x9 in a later cycle -> busyA=0 in the same cycle (BYPASS=1) and stays 0 after.
REQ-034 Issue and writeback on x3 in the same cycle -> x3 holds new data and busy[3]=1; issue x0 -> busy for x0 stays 0.
REQ-035 Assert rst at the 10th clear cycle and also in RUN with busy bits set -> busy clears, ready=0, and ready returns 32 edges after release.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a scoreboard of pending writebacks.
//
// After reset the block clears every register, one per cycle, and then
// raises ready. Until then all reads return 0 and all writes and issues are
// ignored. Register 0 always reads 0, is never written and is never busy.
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst        synchronous active-high reset; restarts initialisation
//   addrA/B    read addresses; dataA/B are combinational read data
//   busyA/B    the addressed register is waiting for a writeback
//   addrD, dataD, RegWEn   writeback port (write also clears busy)
//   issueEn, issueAddr     mark issueAddr as pending (sets busy)
//   ready      initialisation complete, operations accepted
//
// Parameters
//   DATA_LENGTH      register width
//   REG_ADDR_LENGTH  address width
//   MEM_DEPTH        number of registers, 2**REG_ADDR_LENGTH
//   BYPASS           1: a same-cycle writeback is forwarded to the read ports
//
// State  | meaning
// CLEAR  | zeroing REG[cnt], one entry per cycle; ready low
// RUN    | normal operation; ready high
module reg_file_sb #(
    parameter int DATA_LENGTH     = 32,
    parameter int REG_ADDR_LENGTH = 5,
    parameter int MEM_DEPTH       = 32,
    parameter int BYPASS          = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REG_ADDR_LENGTH-1:0] addrA,
    input  logic [REG_ADDR_LENGTH-1:0] addrB,
    output logic [DATA_LENGTH-1:0]     dataA,
    output logic [DATA_LENGTH-1:0]     dataB,
    output logic                       busyA,
    output logic                       busyB,
    input  logic [REG_ADDR_LENGTH-1:0] addrD,
    input  logic [DATA_LENGTH-1:0]     dataD,
    input  logic                       RegWEn,
    input  logic                       issueEn,
    input  logic [REG_ADDR_LENGTH-1:0] issueAddr,
    output logic                       ready
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [REG_ADDR_LENGTH-1:0] LAST_IDX = REG_ADDR_LENGTH'(MEM_DEPTH - 1);

    state_t                     state_q, state_d;
    logic [REG_ADDR_LENGTH-1:0] cnt_q, cnt_d;
    logic [MEM_DEPTH-1:0]       busy_q, busy_d;
    logic [DATA_LENGTH-1:0]     mem_q [MEM_DEPTH];

    logic                       clr_en;
    logic                       wr_en;
    logic                       iss_en;
    logic                       fwd_a, fwd_b;
    logic [DATA_LENGTH-1:0]     rd_a, rd_b;

    assign ready  = (state_q == RUN);
    assign wr_en  = ready && RegWEn  && (addrD     != '0);
    assign iss_en = ready && issueEn && (issueAddr != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        clr_en  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_en = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                busy_d = '0;
                if (cnt_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // Clear first, then set: an issue to the same register
                // in the same cycle as its writeback leaves it busy.
                if (wr_en) begin
                    busy_d[addrD] = 1'b0;
                end
                if (iss_en) begin
                    busy_d[issueAddr] = 1'b1;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    // Storage has no reset of its own; the CLEAR sweep zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_en) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_en) begin
                mem_q[addrD] <= dataD;
            end
        end
    end

    always_comb begin
        rd_a  = (addrA == '0) ? '0 : mem_q[addrA];
        rd_b  = (addrB == '0) ? '0 : mem_q[addrB];
        // wr_en already excludes addrD==0, so forwarding never hits x0.
        fwd_a = (BYPASS != 0) && wr_en && (addrD == addrA);
        fwd_b = (BYPASS != 0) && wr_en && (addrD == addrB);

        dataA = '0;
        dataB = '0;
        busyA = 1'b0;
        busyB = 1'b0;
        if (ready) begin
            dataA = fwd_a ? dataD : rd_a;
            dataB = fwd_b ? dataD : rd_b;
            busyA = busy_q[addrA] && !fwd_a;
            busyB = busy_q[addrB] && !fwd_b;
        end
    end

endmodule
